program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 17 +
 rtl/program_loader.sv | 138 +++++++++++++
 tb/tb_program_loader.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and the
// instruction-width to byte-count derivation.
package program_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_CHECK = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERR   = 3'd4
   } pl_state_e;

   function automatic int bytes_per_instr(input int instr_w);
      return instr_w / 8;
   endfunction

endpackage

// File: rtl/program_loader.sv
// Loads a byte stream into instruction memory, MSB-first per instruction,
// then checks a trailing XOR checksum byte and releases the core on success.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [ADDR_W-1:0]  len,
   input  logic               in_valid,
   input  logic [7:0]         in_data,
   output logic               in_ready,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_waddr,
   output logic [INSTR_W-1:0] mem_wdata,
   output logic               cpu_reset,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int         BYTES     = bytes_per_instr(INSTR_W);
   localparam logic [7:0] LAST_BYTE = 8'(BYTES - 1);

   pl_state_e          state_q, state_d;
   logic [ADDR_W-1:0]  len_q, len_d;
   logic [ADDR_W-1:0]  idx_q, idx_d;
   logic [7:0]         bcnt_q, bcnt_d;
   logic [7:0]         acc_q, acc_d;
   logic [INSTR_W-1:0] asm_q, asm_d;
   logic               we_q, we_d;
   logic [ADDR_W-1:0]  waddr_q, waddr_d;
   logic [INSTR_W-1:0] wdata_q, wdata_d;

   logic               ready_s;
   logic               xfer_s;
   logic [INSTR_W-1:0] asm_next_s;
   logic [ADDR_W-1:0]  idx_inc_s;

   assign ready_s    = (state_q == ST_LOAD) || (state_q == ST_CHECK);
   assign xfer_s     = in_valid & ready_s;
   // Shift left by one byte; the oldest byte falls off the top.
   assign asm_next_s = INSTR_W'({asm_q, in_data});
   assign idx_inc_s  = idx_q + ADDR_W'(1);

   assign in_ready  = ready_s;
   assign busy      = ready_s;
   assign done      = (state_q == ST_DONE);
   assign err       = (state_q == ST_ERR);
   assign cpu_reset = (state_q != ST_DONE);
   assign mem_we    = we_q;
   assign mem_waddr = waddr_q;
   assign mem_wdata = wdata_q;

   // State and datapath registers; reset also drops any half-built word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         bcnt_q  <= 8'd0;
         acc_q   <= 8'h00;
         asm_q   <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         bcnt_q  <= bcnt_d;
         acc_q   <= acc_d;
         asm_q   <= asm_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   // Next-state and datapath update logic.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      bcnt_d  = bcnt_q;
      acc_d   = acc_q;
      asm_d   = asm_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               len_d   = len;
               idx_d   = '0;
               bcnt_d  = 8'd0;
               acc_d   = 8'h00;
               asm_d   = '0;
               state_d = (len == '0) ? ST_CHECK : ST_LOAD;
            end else begin
               state_d = state_q;
            end
         end
         ST_LOAD: begin
            if (xfer_s) begin
               asm_d = asm_next_s;
               acc_d = acc_q ^ in_data;
               if (bcnt_q == LAST_BYTE) begin
                  bcnt_d  = 8'd0;
                  we_d    = 1'b1;
                  waddr_d = idx_q;
                  wdata_d = asm_next_s;
                  idx_d   = idx_inc_s;
                  state_d = (idx_inc_s == len_q) ? ST_CHECK : ST_LOAD;
               end else begin
                  bcnt_d = bcnt_q + 8'd1;
               end
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_CHECK: begin
            if (xfer_s) begin
               state_d = (in_data == acc_q) ? ST_DONE : ST_ERR;
            end else begin
               state_d = ST_CHECK;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: good/bad checksum, empty load, stalls,
// mid-load reset and ignored start, with writes captured on the falling edge.
module tb_program_loader;

   localparam int ADDR_W  = 8;
   localparam int INSTR_W = 16;

   logic               clk;
   logic               reset;
   logic               start;
   logic [ADDR_W-1:0]  len;
   logic               in_valid;
   logic [7:0]         in_data;
   logic               in_ready;
   logic               mem_we;
   logic [ADDR_W-1:0]  mem_waddr;
   logic [INSTR_W-1:0] mem_wdata;
   logic               cpu_reset;
   logic               busy;
   logic               done;
   logic               err;

   int vectors = 0;
   int miscompares = 0;

   logic [ADDR_W-1:0]  wa[$];
   logic [INSTR_W-1:0] wd[$];

   program_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata),
      .cpu_reset (cpu_reset),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Capture every write strobe mid-cycle.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wa.push_back(mem_waddr);
         wd.push_back(mem_wdata);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [ADDR_W-1:0] l);
      @(negedge clk);
      start = 1'b1;
      len   = l;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int waited;
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      waited   = 0;
      while (in_ready !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check("byte_accept_timeout", 32'(waited < 50), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"},  32'(in_ready),  32'd0);
      check({tag, "_mem_we"},    32'(mem_we),    32'd0);
      check({tag, "_mem_waddr"}, 32'(mem_waddr), 32'd0);
      check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
      check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
      check({tag, "_busy"},      32'(busy),      32'd0);
      check({tag, "_done"},      32'(done),      32'd0);
      check({tag, "_err"},       32'(err),       32'd0);
   endtask

   task automatic check_two_writes(input string tag);
      check({tag, "_nwrites"}, 32'(wa.size()), 32'd2);
      if (wa.size() == 2) begin
         check({tag, "_addr0"}, 32'(wa[0]), 32'h00);
         check({tag, "_data0"}, 32'(wd[0]), 32'h1234);
         check({tag, "_addr1"}, 32'(wa[1]), 32'h01);
         check({tag, "_data1"}, 32'(wd[1]), 32'hABCD);
      end
   endtask

   task automatic run_load(input logic [7:0] csum, input int max_gap);
      logic [7:0] bytes_q[4];
      bytes_q[0] = 8'h12; bytes_q[1] = 8'h34; bytes_q[2] = 8'hAB; bytes_q[3] = 8'hCD;
      wa.delete();
      wd.delete();
      do_start(8'd2);
      for (int i = 0; i < 4; i++) send_byte(bytes_q[i], int'($urandom_range(max_gap, 0)));
      send_byte(csum, int'($urandom_range(max_gap, 0)));
      @(negedge clk);
   endtask

   initial begin
      reset    = 1'b0;
      start    = 1'b0;
      len      = '0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (2) @(negedge clk);
      check_reset_outputs("por");
      reset = 1'b1;
      @(negedge clk);
      check("idle_in_ready", 32'(in_ready), 32'd0);

      // Good checksum; also look at status mid-load.
      wa.delete();
      wd.delete();
      do_start(8'd2);
      check("load_busy", 32'(busy), 32'd1);
      check("load_cpu_reset", 32'(cpu_reset), 32'd1);
      check("load_in_ready", 32'(in_ready), 32'd1);
      send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'hAB, 0); send_byte(8'hCD, 0);
      check("check_busy", 32'(busy), 32'd1);
      send_byte(8'h40, 0);
      @(negedge clk);
      check_two_writes("good");
      check("good_done", 32'(done), 32'd1);
      check("good_err", 32'(err), 32'd0);
      check("good_cpu_reset", 32'(cpu_reset), 32'd0);
      check("good_in_ready", 32'(in_ready), 32'd0);
      check("good_busy", 32'(busy), 32'd0);

      // Bad checksum.
      run_load(8'h41, 0);
      check_two_writes("bad");
      check("bad_err", 32'(err), 32'd1);
      check("bad_done", 32'(done), 32'd0);
      check("bad_cpu_reset", 32'(cpu_reset), 32'd1);
      check("bad_in_ready", 32'(in_ready), 32'd0);

      // Empty load: only the checksum byte.
      wa.delete();
      wd.delete();
      do_start(8'd0);
      check("len0_busy", 32'(busy), 32'd1);
      send_byte(8'h00, 0);
      @(negedge clk);
      check("len0_nwrites", 32'(wa.size()), 32'd0);
      check("len0_done", 32'(done), 32'd1);
      check("len0_cpu_reset", 32'(cpu_reset), 32'd0);

      // Random stall gaps.
      for (int r = 0; r < 3; r++) begin
         run_load(8'h40, 3);
         check_two_writes("gap");
         check("gap_done", 32'(done), 32'd1);
         check("gap_in_ready", 32'(in_ready), 32'd0);
      end

      // Reset mid-load after three bytes: the half word must never appear.
      wa.delete();
      wd.delete();
      do_start(8'd2);
      send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'hAB, 0);
      check("abort_nwrites_before", 32'(wa.size()), 32'd1);
      reset = 1'b0;
      #1;
      check_reset_outputs("abort");
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("abort_nwrites_after", 32'(wa.size()), 32'd1);
      check("abort_idle_in_ready", 32'(in_ready), 32'd0);
      run_load(8'h40, 0);
      check_two_writes("rerun");
      check("rerun_done", 32'(done), 32'd1);

      // Start pulsed during LOAD is ignored.
      wa.delete();
      wd.delete();
      do_start(8'd2);
      send_byte(8'h12, 0);
      do_start(8'd5);
      check("ign_busy", 32'(busy), 32'd1);
      send_byte(8'h34, 0); send_byte(8'hAB, 0); send_byte(8'hCD, 0);
      send_byte(8'h40, 0);
      @(negedge clk);
      check_two_writes("ign");
      check("ign_done", 32'(done), 32'd1);
      check("ign_cpu_reset", 32'(cpu_reset), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
